// File: rtl/renkon_conv_lane_if.sv
// Bus bundle for one renkon convolution lane: weight/bias load, window beats and result.
interface renkon_conv_lane_if #(
  parameter int DWIDTH = 16,
  parameter int FSIZE  = 3,
  parameter int FACCUM = 10
);
  logic                                  wreg_clr;
  logic                                  wreg_we;
  logic [DWIDTH-1:0]                     weight_in;
  logic                                  bias_we;
  logic [DWIDTH-1:0]                     bias_in;
  logic                                  in_valid;
  logic                                  in_first;
  logic                                  in_last;
  logic [FACCUM-1:0]                     in_addr;
  logic [FSIZE*FSIZE-1:0][DWIDTH-1:0]    pixel_in;
  logic                                  relu_en;
  logic                                  weight_ready;
  logic                                  busy;
  logic                                  out_valid;
  logic [FACCUM-1:0]                     out_addr;
  logic [DWIDTH-1:0]                     pixel_out;

  modport master (
    output wreg_clr, wreg_we, weight_in, bias_we, bias_in,
           in_valid, in_first, in_last, in_addr, pixel_in, relu_en,
    input  weight_ready, busy, out_valid, out_addr, pixel_out
  );
  modport slave (
    input  wreg_clr, wreg_we, weight_in, bias_we, bias_in,
           in_valid, in_first, in_last, in_addr, pixel_in, relu_en,
    output weight_ready, busy, out_valid, out_addr, pixel_out
  );
endinterface

// File: rtl/renkon_conv_lane.sv
// One output channel: window x kernel, rounded tree sum, cross-channel accumulation
// in a partial-sum buffer with forwarding, then bias and optional ReLU.
module renkon_conv_mul #(
  parameter int DWIDTH = 16
) (
  input  logic                       clk,
  input  logic                       xrst,
  input  logic signed [DWIDTH-1:0]   a,
  input  logic signed [DWIDTH-1:0]   b,
  output logic signed [2*DWIDTH-1:0] p
);
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) p <= '0;
    else       p <= a * b;
endmodule

module renkon_conv_lane #(
  parameter int DWIDTH = 16,
  parameter int FSIZE  = 3,
  parameter int FACCUM = 10,
  parameter int FRAC   = 8
) (
  input logic               clk,
  input logic               xrst,
  renkon_conv_lane_if.slave bus
);
  localparam int N      = FSIZE * FSIZE;
  localparam int IW     = $clog2(N);
  localparam int SW     = 2 * DWIDTH + $clog2(N);
  localparam int XW     = SW + 1;
  localparam int STAGES = 3;
  localparam logic signed [XW-1:0] SMAX = {{(XW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {{(XW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  if (!(FSIZE == 3 || FSIZE == 5)) begin : g_bad_fsize
    $error("renkon_conv_lane: FSIZE must be 3 or 5");
  end
  if (FRAC < 1) begin : g_bad_frac
    $error("renkon_conv_lane: FRAC must be >= 1");
  end

  function automatic logic signed [DWIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SMAX)      return {1'b0, {(DWIDTH-1){1'b1}}};
    else if (v < SMIN) return {1'b1, {(DWIDTH-1){1'b0}}};
    else               return v[DWIDTH-1:0];
  endfunction

  logic [N-1:0][DWIDTH-1:0]   kernel;
  logic [IW-1:0]              widx;
  logic                       wready;
  logic signed [DWIDTH-1:0]   bias;

  logic [STAGES:0]            vld_pipe;
  logic [N-1:0][DWIDTH-1:0]   win0;
  logic [N-1:0][2*DWIDTH-1:0] prod1;
  logic [FACCUM-1:0]          addr0, addr1, addr2, addr3, addr4;
  logic                       first0, first1, first2;
  logic                       last0, last1, last2, last3;
  logic                       relu0, relu1, relu2;
  logic signed [DWIDTH-1:0]   r2, rdata2, acc3, acc4, fin3;
  logic                       wr_vld4;
  logic                       ovalid;
  logic [FACCUM-1:0]          oaddr;
  logic [DWIDTH-1:0]          opix;

  logic signed [SW-1:0]       s;
  logic signed [XW-1:0]       rnd;
  logic signed [DWIDTH-1:0]   r_c, old, acc_c, fin_c;

  logic [DWIDTH-1:0]          mem [2**FACCUM];

  // Clear wins over a same-cycle write; the write is dropped entirely.
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      kernel <= '0;
      widx   <= '0;
      wready <= 1'b0;
      bias   <= '0;
    end else begin
      if (bus.wreg_clr) begin
        widx   <= '0;
        wready <= 1'b0;
      end else if (bus.wreg_we) begin
        kernel[widx] <= bus.weight_in;
        if (widx == IW'(N-1)) begin
          widx   <= '0;
          wready <= 1'b1;
        end else begin
          widx <= widx + 1'b1;
        end
      end
      if (bus.bias_we) bias <= bus.bias_in;
    end

  for (genvar i = 0; i < N; i++) begin : g_mul
    renkon_conv_mul #(.DWIDTH(DWIDTH)) u_mul (
      .clk (clk),
      .xrst(xrst),
      .a   (win0[i]),
      .b   (kernel[i]),
      .p   (prod1[i])
    );
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < N; i++) s = s + SW'($signed(prod1[i]));
    rnd = XW'(s) + XW'(2**(FRAC-1));
    r_c = sat(rnd >>> FRAC);
    // Newest pending write to this address wins over the (possibly stale) buffer read.
    if (vld_pipe[3] && addr3 == addr2)  old = acc3;
    else if (wr_vld4 && addr4 == addr2) old = acc4;
    else                                old = rdata2;
    acc_c = first2 ? r2 : sat(XW'(old) + XW'(r2));
    fin_c = sat(XW'(acc_c) + XW'(bias));
    if (relu2 && fin_c[DWIDTH-1]) fin_c = '0;
  end

  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      vld_pipe <= '0;
      win0 <= '0;
      {addr0, addr1, addr2, addr3, addr4} <= '0;
      {first0, first1, first2} <= '0;
      {last0, last1, last2, last3} <= '0;
      {relu0, relu1, relu2} <= '0;
      {r2, acc3, acc4, fin3} <= '0;
      wr_vld4 <= 1'b0;
      ovalid  <= 1'b0;
      oaddr   <= '0;
      opix    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
      if (bus.in_valid) begin
        win0   <= bus.pixel_in;
        addr0  <= bus.in_addr;
        first0 <= bus.in_first;
        last0  <= bus.in_last;
        relu0  <= bus.relu_en;
      end
      addr1 <= addr0;  first1 <= first0; last1 <= last0; relu1 <= relu0;
      r2    <= r_c;    addr2  <= addr1;  first2 <= first1; last2 <= last1; relu2 <= relu1;
      acc3  <= acc_c;  addr3  <= addr2;  fin3  <= fin_c;  last3 <= last2;
      acc4  <= acc3;   addr4  <= addr3;  wr_vld4 <= vld_pipe[3];
      ovalid <= vld_pipe[3] & last3;
      if (vld_pipe[3] & last3) begin
        oaddr <= addr3;
        opix  <= fin3;
      end
    end

  // Buffer contents are deliberately not reset.
  always_ff @(posedge clk) begin
    rdata2 <= mem[addr1];
    if (vld_pipe[2]) mem[addr2] <= acc_c;
  end

  assign bus.weight_ready = wready;
  assign bus.busy         = |vld_pipe;
  assign bus.out_valid    = ovalid;
  assign bus.out_addr     = oaddr;
  assign bus.pixel_out    = opix;
endmodule

// File: tb/tb_renkon_conv_lane.sv
// Randomised bench for renkon_conv_lane against a sequential arithmetic model.
module tb_renkon_conv_lane;
  localparam int DW = 16, FS = 3, FA = 10, FR = 8, N = FS * FS;

  logic clk = 1'b0;
  logic xrst = 1'b0;
  always #5 clk = ~clk;

  renkon_conv_lane_if #(.DWIDTH(DW), .FSIZE(FS), .FACCUM(FA)) bus();
  renkon_conv_lane #(.DWIDTH(DW), .FSIZE(FS), .FACCUM(FA), .FRAC(FR)) dut (
    .clk (clk),
    .xrst(xrst),
    .bus (bus)
  );

  typedef struct { int addr; int pix; int cyc; } exp_t;
  exp_t eq[$];
  exp_t mon_e;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int mk[N], kw[N], win[N];
  int mbias = 0, midx = 0;
  int psum[1024];
  bit pinit[1024];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    bus.wreg_clr = 0; bus.wreg_we = 0; bus.bias_we = 0;
    bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0; bus.relu_en = 0;
  endtask

  task automatic wr_weight(input int v);
    step();
    bus.wreg_we = 1; bus.weight_in = v[15:0];
    mk[midx] = v; midx = (midx + 1) % N;
  endtask

  task automatic load_kernel();
    step();
    bus.wreg_clr = 1; midx = 0;
    for (int i = 0; i < N; i++) wr_weight(kw[i]);
  endtask

  task automatic ident(input int c);
    for (int i = 0; i < N; i++) kw[i] = (i == N/2) ? c : 0;
    load_kernel();
  endtask

  task automatic set_bias(input int v);
    step();
    bus.bias_we = 1; bus.bias_in = v[15:0]; mbias = v;
  endtask

  task automatic setwin(input int c);
    for (int i = 0; i < N; i++) win[i] = (i == N/2) ? c : int'($urandom_range(0, 2000)) - 1000;
  endtask

  task automatic beat(input int a, input bit f, input bit l, input bit rl);
    longint s, r, acc, fin;
    exp_t e;
    step();
    bus.in_valid = 1; bus.in_first = f; bus.in_last = l; bus.relu_en = rl;
    bus.in_addr = a[FA-1:0];
    for (int i = 0; i < N; i++) bus.pixel_in[i] = win[i][DW-1:0];
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(win[i]) * longint'(mk[i]);
    r = sat((s + (longint'(1) << (FR-1))) >>> FR);
    acc = f ? r : sat(longint'(psum[a]) + r);
    psum[a] = int'(acc); pinit[a] = 1;
    if (l) begin
      fin = sat(acc + mbias);
      if (rl && fin < 0) fin = 0;
      e.addr = a; e.pix = int'(fin); e.cyc = cyc + 5;
      eq.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    step();
    while (eq.size() != 0 && n < 40) begin @(posedge clk); n++; end
    chk("drain_outstanding", eq.size(), 0);
    eq.delete();
    repeat (2) step();
  endtask

  always @(negedge clk) begin
    if (xrst && bus.out_valid === 1'b1) begin
      if (eq.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        mon_e = eq.pop_front();
        chk("out_addr", bus.out_addr, mon_e.addr);
        chk("pixel_out", $signed(bus.pixel_out), mon_e.pix);
        chk("latency_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    int a;
    bit f, l, rl;
    bus.wreg_clr = 0; bus.wreg_we = 0; bus.weight_in = '0; bus.bias_we = 0; bus.bias_in = '0;
    bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0; bus.in_addr = '0;
    bus.pixel_in = '0; bus.relu_en = 0;
    for (int i = 0; i < N; i++) mk[i] = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_addr", bus.out_addr, 0);
    chk("rst_pixel_out", bus.pixel_out, 0);
    chk("rst_weight_ready", bus.weight_ready, 0);
    chk("rst_busy", bus.busy, 0);
    xrst = 1;

    // weight index: ready after 9th write, 10th wraps to slot 0
    for (int i = 0; i < 8; i++) wr_weight(i == 0 ? 77 : (i == N/2 ? 256 : 0));
    step(); chk("wready_after8", bus.weight_ready, 0);
    wr_weight(0);
    step(); chk("wready_after9", bus.weight_ready, 1);
    wr_weight(0);
    setwin(100); win[0] = 500; beat(5, 1, 1, 0);
    drain();

    // clear beats a simultaneous write
    step(); bus.wreg_clr = 1; bus.wreg_we = 1; bus.weight_in = 16'h1234; midx = 0;
    step(); chk("wready_clr", bus.weight_ready, 0);
    for (int i = 0; i < 8; i++) wr_weight(i == N/2 ? 256 : 0);
    step(); chk("wready_clr_after8", bus.weight_ready, 0);
    wr_weight(0);
    step(); chk("wready_clr_after9", bus.weight_ready, 1);
    setwin(100); beat(12, 1, 1, 0);
    drain();

    // back-to-back accumulation and interleaved forwarding
    set_bias(5);
    setwin(100); beat(7, 1, 0, 0);
    setwin(100); beat(7, 0, 0, 0);
    setwin(100); beat(7, 0, 1, 0);
    setwin(40);  beat(7, 1, 0, 0);
    setwin(-30); beat(8, 1, 0, 0);
    setwin(25);  beat(7, 0, 0, 0);
    setwin(60);  beat(8, 0, 1, 0);
    setwin(11);  beat(7, 0, 1, 0);
    drain();
    set_bias(0);

    // rounding half up
    ident(128);
    setwin(3);  beat(1, 1, 1, 0);
    setwin(-3); beat(2, 1, 1, 0);
    setwin(1);  beat(1, 1, 1, 0);
    setwin(-1); beat(2, 1, 1, 0);
    drain();

    // saturation both ways
    for (int i = 0; i < N; i++) kw[i] = 32767;
    load_kernel();
    for (int i = 0; i < N; i++) win[i] = 32767;
    beat(3, 1, 1, 0);
    for (int i = 0; i < N; i++) win[i] = -32768;
    beat(4, 1, 1, 0);
    drain();
    ident(256);
    setwin(20000);  beat(6, 1, 0, 0);
    setwin(20000);  beat(6, 0, 1, 0);
    setwin(-20000); beat(6, 1, 0, 0);
    setwin(-20000); beat(6, 0, 1, 0);
    drain();

    // ReLU
    setwin(-50); beat(20, 1, 1, 1);
    setwin(-50); beat(21, 1, 1, 0);
    drain();

    // randomised traffic
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) kw[i] = int'($urandom_range(0, 6000)) - 3000;
      load_kernel();
      set_bias(int'($urandom_range(0, 10000)) - 5000);
      for (int k = 0; k < 40; k++) begin
        a  = int'($urandom_range(0, 3));
        f  = !pinit[a] || ($urandom % 4 == 0);
        l  = ($urandom % 3 == 0);
        rl = $urandom % 2;
        for (int i = 0; i < N; i++) win[i] = int'($urandom_range(0, 65535)) - 32768;
        beat(a, f, l, rl);
        if ($urandom % 5 == 0) step();
      end
      drain();
    end

    // reset with three beats in flight
    ident(256);
    setwin(100); beat(9, 1, 1, 0);
    setwin(-7);  beat(10, 1, 1, 0);
    setwin(33);  beat(11, 1, 1, 0);
    @(posedge clk); #1;
    chk("busy_inflight", bus.busy, 1);
    xrst = 0;
    eq.delete();
    bus.in_valid = 0; bus.in_first = 0; bus.in_last = 0;
    repeat (2) @(posedge clk); #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_weight_ready", bus.weight_ready, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    xrst = 1;
    for (int i = 0; i < N; i++) mk[i] = 0;
    for (int i = 0; i < 1024; i++) pinit[i] = 0;
    midx = 0; mbias = 0;
    repeat (8) step();
    chk("postrst_busy", bus.busy, 0);
    ident(256);
    setwin(-123); beat(9, 1, 1, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/renkon_conv_lane.md
# renkon_conv_lane

Parametrised successor convolution lane for the renkon accelerator. Each lane computes one output channel. It loads an FSIZE×FSIZE kernel and a bias serially, then multiplies each incoming pixel window by the kernel and reduces the products through a pipelined adder tree. Per-window results are rounded from fixed point and accumulated across input channels in a dual-port partial-sum buffer, with read-after-write forwarding. On the last input channel it adds the bias, applies optional ReLU and emits the output pixel with a valid strobe.

## Interface
- DWIDTH, 16, pixel/weight/bias/output width (signed two's complement)
- FSIZE, 3, kernel side; 3 or 5 supported, anything else is an elaboration error
- FACCUM, 10, partial-sum buffer address width (depth 2**FACCUM)
- FRAC, 8, fraction bits of weights; must be ≥1
- clk  in  1  clock, all state on rising edge
- xrst  in  1  reset, asynchronous, active-low
- wreg_clr  in  1  clears the weight index counter and weight_ready
- wreg_we  in  1  writes weight_in to kernel slot [index], then increments the index
- weight_in  in  DWIDTH  serial kernel coefficient, row-major
- bias_we  in  1  loads bias_in
- bias_in  in  DWIDTH  bias, integer scale (same scale as pixel_out)
- in_valid  in  1  pixel window beat
- in_first  in  1  first input channel for in_addr; ignore stored sum
- in_last  in  1  last input channel; emit result
- in_addr  in  FACCUM  output pixel position
- pixel_in  in  FSIZE**2 × DWIDTH  window, row-major
- relu_en  in  1  sampled with the beat; clamps negatives on the last beat
- weight_ready  out  1  all FSIZE**2 slots written since reset/wreg_clr
- busy  out  1  any pipeline stage holds a valid beat
- out_valid  out  1  one-cycle strobe per in_last beat
- out_addr  out  FACCUM  in_addr of the emitted beat
- pixel_out  out  DWIDTH  final result

## Operation
- Weight load: the index counts 0..FSIZE²−1 and wraps to 0. weight_ready sets when slot FSIZE²−1 is written and stays set until wreg_clr or reset. wreg_clr has priority over wreg_we in the same cycle.
- Stages, for a beat sampled at edge t:
  - S0 (t): register the window, addr, first, last and relu_en.
  - S1 (t+1): FSIZE² products of 2·DWIDTH bits are registered using the weights current at that edge. A buffer read is issued at addr.
  - S2 (t+2): full-precision tree sum s; r = sat_DWIDTH((s + 2^(FRAC−1)) >>> FRAC), i.e. round half up and saturate. The buffer read data is returned.
  - S3 (t+3): acc = first ? r : sat_DWIDTH(old + r). acc is written to the buffer at addr. If last: f = sat_DWIDTH(acc + bias), then ReLU if relu_en.
  - Output (t+4): out_valid, out_addr and pixel_out are registered.
- Forwarding: old is the newest of the following, in priority order:
  - the S3 write of the previous beat, if its addr matches;
  - the write of the beat before that, if its addr matches;
  - the buffer data.
  This makes back-to-back same-address beats correct.
- in_valid may be asserted every cycle. There is no backpressure.
- A beat with both in_first and in_last set is a single-channel pass.
- Beats with in_valid low are ignored entirely, including first/last.

## Timing
- Latency: in_valid at edge t → out_valid high during cycle t+4, exactly one cycle per last beat.
- Throughput: 1 beat/cycle. Consecutive last beats give consecutive out_valid cycles.
- A weight or bias write at edge e affects beats whose S1 (weights) or S3 (bias) occurs after e.
- Reset values: out_valid 0, out_addr 0, pixel_out 0, weight_ready 0, busy 0. Index counter, kernel and bias are 0. All stage valids are cleared.
- Buffer contents are not reset. The first pass after reset must use in_first.
- Reset mid-operation discards in-flight beats. No out_valid is produced for them.

## Test plan
- Weight load: 9 wreg_we writes → weight_ready rises after the 9th. A 10th write goes to slot 0. wreg_clr together with wreg_we → index 0, weight_ready 0.
- Identity: center weight 256, others 0, bias 0, window center 100, first&last at t → out_valid at t+4, pixel_out 100, out_addr as driven.
- Back-to-back accumulate: three consecutive beats at addr 7, center pixels 100/100/100, first on beat 1, last on beat 3, bias 5 → single output 305. Repeat interleaving addr 7/8/7 → forwarding correct.
- Rounding/saturation: center weight 128, pixel 3 → 2; pixel −3 → −1. All weights and pixels 32767 → 32767. Accumulating 20000+20000 → 32767.
- ReLU: result −50 with relu_en=1 → 0; relu_en=0 → −50.
- Reset with 3 beats in flight → no out_valid, busy 0, weight_ready 0. A subsequent identity pass → correct.
